// File: rtl/pc_sequencer.sv
// Fetch-side program counter sequencer: issues handshaked, stallable fetch requests
// and applies branch/jump redirects, trapping on misaligned targets.
module pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_write,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    output logic [31:0] pc_out,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        flush,
    output logic        misalign_trap,
    output logic [31:0] trap_epc,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_RST   = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      state_reg;
    logic [31:0] pc_reg;
    logic        pend_reg;
    logic [31:0] pend_pc_reg;
    logic [31:0] trap_epc_reg;
    logic [31:0] fetch_count_reg;

    logic        in_fetch;
    logic        in_hold;
    logic        misaligned;
    logic        redirect_live;
    logic [31:0] eff_target;
    logic [31:0] pc_plus4_next;

    assign in_fetch      = (state_reg == ST_FETCH);
    assign in_hold       = (state_reg == ST_HOLD);
    assign misaligned    = (redirect_target[1:0] != 2'b00);
    assign eff_target    = misaligned ? TRAP_VECTOR : redirect_target;
    assign pc_plus4_next = pc_reg + 32'd4;

    // Redirects are ignored while leaving reset; elsewhere their side effects are immediate.
    assign redirect_live = redirect_valid & (in_fetch | in_hold);

    assign imem_req      = in_fetch;
    assign imem_addr     = pc_reg;
    assign pc_out        = pc_reg;
    assign pc_plus4      = pc_plus4_next;
    assign fetch_valid   = in_fetch & imem_ready & ~redirect_valid & ~pend_reg;
    assign flush         = redirect_live;
    assign misalign_trap = redirect_live & misaligned;
    assign trap_epc      = trap_epc_reg;
    assign fetch_count   = fetch_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= ST_RST;
            pc_reg          <= RESET_VECTOR;
            pend_reg        <= 1'b0;
            pend_pc_reg     <= 32'd0;
            trap_epc_reg    <= 32'd0;
            fetch_count_reg <= 32'd0;
        end else begin
            if (misalign_trap) begin
                trap_epc_reg <= redirect_target;
            end
            if (fetch_valid) begin
                fetch_count_reg <= fetch_count_reg + 32'd1;
            end

            case (state_reg)
                ST_RST: begin
                    state_reg <= pc_write ? ST_FETCH : ST_HOLD;
                end
                ST_FETCH: begin
                    if (imem_ready) begin
                        if (redirect_valid) begin
                            pc_reg <= eff_target;
                        end else if (pend_reg) begin
                            pc_reg <= pend_pc_reg;
                        end else begin
                            pc_reg <= pc_plus4_next;
                        end
                        pend_reg  <= 1'b0;
                        state_reg <= pc_write ? ST_FETCH : ST_HOLD;
                    end else if (redirect_valid) begin
                        // The outstanding request keeps its address; the redirect waits for completion.
                        pend_reg    <= 1'b1;
                        pend_pc_reg <= eff_target;
                    end
                end
                ST_HOLD: begin
                    if (redirect_valid) begin
                        pc_reg <= eff_target;
                    end
                    if (pc_write) begin
                        state_reg <= ST_FETCH;
                    end
                end
                default: begin
                    state_reg <= ST_RST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized checking of pc_sequencer against a cycle-level behavioural model.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_V = 32'h0000_0000;
    localparam logic [31:0] TRAP_V  = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset;
    logic        pc_write;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        fetch_valid;
    logic        flush;
    logic        misalign_trap;
    logic [31:0] trap_epc;
    logic [31:0] fetch_count;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .pc_write        (pc_write),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .pc_out          (pc_out),
        .pc_plus4        (pc_plus4),
        .fetch_valid     (fetch_valid),
        .flush           (flush),
        .misalign_trap   (misalign_trap),
        .trap_epc        (trap_epc),
        .fetch_count     (fetch_count)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit checking = 1'b0;

    // Model: mode 0 = just out of reset, 1 = request outstanding, 2 = holding
    int          m_mode;
    logic [31:0] m_pc;
    bit          m_pend;
    logic [31:0] m_pend_pc;
    logic [31:0] m_epc;
    logic [31:0] m_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic cycle(input bit rst, input bit pw, input bit rv,
                         input logic [31:0] rt, input bit rdy);
        bit          mis;
        bit          act;
        bit          e_fv;
        logic [31:0] tgt;
        reset           = rst;
        pc_write        = pw;
        redirect_valid  = rv;
        redirect_target = rt;
        imem_ready      = rdy;
        #1;
        mis  = (rt[1:0] != 2'b00);
        tgt  = mis ? TRAP_V : rt;
        act  = (m_mode != 0) && rv;
        e_fv = (m_mode == 1) && rdy && !rv && !m_pend;
        if (checking) begin
            chk("imem_req",      {31'd0, imem_req},      {31'd0, (m_mode == 1)});
            chk("imem_addr",     imem_addr,              m_pc);
            chk("pc_out",        pc_out,                 m_pc);
            chk("pc_plus4",      pc_plus4,               m_pc + 32'd4);
            chk("fetch_valid",   {31'd0, fetch_valid},   {31'd0, e_fv});
            chk("flush",         {31'd0, flush},         {31'd0, act});
            chk("misalign_trap", {31'd0, misalign_trap}, {31'd0, act && mis});
            chk("trap_epc",      trap_epc,               m_epc);
            chk("fetch_count",   fetch_count,            m_cnt);
        end
        $display("[TB] cyc=%0d rst=%0b pw=%0b rv=%0b rt=%h rdy=%0b req=%0b addr=%h fv=%0b fl=%0b tr=%0b cnt=%0d",
                 cyc, rst, pw, rv, rt, rdy, imem_req, imem_addr, fetch_valid, flush, misalign_trap, fetch_count);
        @(posedge clk);
        if (rst) begin
            m_mode    = 0;
            m_pc      = RESET_V;
            m_pend    = 1'b0;
            m_pend_pc = 32'd0;
            m_epc     = 32'd0;
            m_cnt     = 32'd0;
            checking  = 1'b1;
        end else begin
            if (act && mis) m_epc = rt;
            if (e_fv) m_cnt = m_cnt + 32'd1;
            if (m_mode == 0) begin
                m_mode = pw ? 1 : 2;
            end else if (m_mode == 1) begin
                if (rdy) begin
                    m_pc   = rv ? tgt : (m_pend ? m_pend_pc : m_pc + 32'd4);
                    m_pend = 1'b0;
                    m_mode = pw ? 1 : 2;
                end else if (rv) begin
                    m_pend    = 1'b1;
                    m_pend_pc = tgt;
                end
            end else begin
                if (rv) m_pc = tgt;
                if (pw) m_mode = 1;
            end
        end
        #1;
        cyc++;
    endtask

    initial begin
        logic [31:0] rt;
        m_mode = 0; m_pc = RESET_V; m_pend = 1'b0; m_pend_pc = 32'd0; m_epc = 32'd0; m_cnt = 32'd0;
        reset = 1'b1; pc_write = 1'b0; redirect_valid = 1'b0; redirect_target = 32'd0; imem_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset and a zero-wait fetch run
        cycle(1, 0, 0, 32'd0, 0);
        cycle(1, 0, 0, 32'd0, 0);
        cycle(0, 1, 0, 32'd0, 0);
        repeat (4) cycle(0, 1, 0, 32'd0, 1);
        chk("run_count", fetch_count, 32'd4);
        chk("run_addr", imem_addr, 32'd16);

        // Stall at pc=8 with a redirect in the middle of the wait
        cycle(1, 0, 0, 32'd0, 0);
        cycle(0, 1, 0, 32'd0, 0);
        cycle(0, 1, 0, 32'd0, 1);
        cycle(0, 1, 0, 32'd0, 1);
        cycle(0, 1, 0, 32'd0, 0);
        cycle(0, 1, 1, 32'h40, 0);
        cycle(0, 1, 0, 32'd0, 0);
        chk("stall_addr", imem_addr, 32'd8);
        cycle(0, 1, 0, 32'd0, 1);
        chk("pend_addr", imem_addr, 32'h40);

        // pc_write drops while ready arrives, then a misaligned redirect in HOLD
        cycle(0, 0, 0, 32'd0, 1);
        chk("hold_req", {31'd0, imem_req}, 32'd0);
        chk("hold_pc", pc_out, 32'h44);
        cycle(0, 0, 0, 32'd0, 0);
        cycle(0, 0, 1, 32'h42, 0);
        chk("trap_epc_dir", trap_epc, 32'h42);
        chk("trap_pc", pc_out, TRAP_V);
        cycle(0, 1, 0, 32'd0, 0);
        chk("resume_req", {31'd0, imem_req}, 32'd1);

        // Redirect coinciding with ready, then PC wrap, then reset mid-request
        cycle(0, 1, 1, 32'h80, 1);
        chk("same_cycle_addr", imem_addr, 32'h80);
        cycle(0, 1, 1, 32'hFFFF_FFFC, 1);
        cycle(0, 1, 0, 32'd0, 1);
        chk("wrap_addr", imem_addr, 32'd0);
        cycle(0, 1, 0, 32'd0, 1);
        cycle(0, 1, 0, 32'd0, 0);
        cycle(1, 1, 0, 32'd0, 0);
        chk("reset_req", {31'd0, imem_req}, 32'd0);
        chk("reset_pc", pc_out, RESET_V);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rt = $urandom;
            if ($urandom_range(0, 2) != 0) rt[1:0] = 2'b00;
            if ($urandom_range(0, 9) == 0) rt = 32'hFFFF_FFF8;
            cycle(($urandom_range(0, 99) < 2), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 6) == 0), rt, ($urandom_range(0, 9) < 6));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
